// File: rtl/edge_pkg.sv
// Shared constants for the edge-detection pipeline: pixel/result widths,
// default frame geometry and the z1..z9 window slot indices.
package edge_pkg;

    localparam int PIX_W        = 8;
    localparam int SOBEL_OUT_W  = 12;
    localparam int IMG_ROWS_DEF = 436;
    localparam int IMG_COLS_DEF = 576;

    // Window slots, row-major: z1 z2 z3 / z4 z5 z6 / z7 z8 z9
    localparam int Z1 = 0;
    localparam int Z2 = 1;
    localparam int Z3 = 2;
    localparam int Z4 = 3;
    localparam int Z5 = 4;
    localparam int Z6 = 5;
    localparam int Z7 = 6;
    localparam int Z8 = 7;
    localparam int Z9 = 8;

    function automatic int win_idx(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: asynchronous read, synchronous write,
// so a read and a write to the same address in one cycle returns the old value.
module line_buffer #(
    parameter int DEPTH = 576,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream 3x3 window generator feeding z1..z9 of the Sobel datapath.
// Define SOBEL_WIN_LAST_EN to add the win_last end-of-frame flag.
module sobel_window_gen #(
    parameter int IMG_ROWS = edge_pkg::IMG_ROWS_DEF,
    parameter int IMG_COLS = edge_pkg::IMG_COLS_DEF,
    parameter int PIX_W    = edge_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic [PIX_W-1:0] z9,
    output logic             win_valid,
    input  logic             win_ready
`ifdef SOBEL_WIN_LAST_EN
    ,
    output logic             win_last
`endif
);
    import edge_pkg::*;

    localparam int RW = $clog2(IMG_ROWS);
    localparam int CW = $clog2(IMG_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          win_fire;
    logic [PIX_W-1:0] new_rd;
    logic [PIX_W-1:0] old_rd;

    // Columns indexed [0]=row-2, [1]=row-1, [2]=row; col_a is two columns back
    logic [2:0][PIX_W-1:0] col_a, col_b, new_col;
    logic [8:0][PIX_W-1:0] win_d, z_q;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign win_fire  = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Newer buffer holds row-1; its displaced entry ages into the older buffer
    line_buffer #(.DEPTH(IMG_COLS), .W(PIX_W), .AW(CW)) u_lb_new (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (pix_in),
        .rdata (new_rd)
    );

    line_buffer #(.DEPTH(IMG_COLS), .W(PIX_W), .AW(CW)) u_lb_old (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (new_rd),
        .rdata (old_rd)
    );

    assign new_col[0] = old_rd;
    assign new_col[1] = new_rd;
    assign new_col[2] = pix_in;

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            win_d[win_idx(r, 0)] = col_a[r];
            win_d[win_idx(r, 1)] = col_b[r];
            win_d[win_idx(r, 2)] = new_col[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_a <= '0;
            col_b <= '0;
        end else if (accept) begin
            col_a <= col_b;
            col_b <= new_col;
        end
    end

    // Output register only advances when the consumer is not stalling it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            z_q       <= '0;
        end else if (pix_ready) begin
            win_valid <= win_fire;
            if (win_fire) z_q <= win_d;
        end
    end

`ifdef SOBEL_WIN_LAST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         win_last <= 1'b0;
        else if (pix_ready) win_last <= win_fire && (row == ROW_LAST) && (col == COL_LAST);
    end
`endif

    assign z1 = z_q[Z1];
    assign z2 = z_q[Z2];
    assign z3 = z_q[Z3];
    assign z4 = z_q[Z4];
    assign z5 = z_q[Z5];
    assign z6 = z_q[Z6];
    assign z7 = z_q[Z7];
    assign z8 = z_q[Z8];
    assign z9 = z_q[Z9];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 3x4 instance for directed cases and
// a 5x5 instance for randomized handshakes, both checked against a frame-array model.
module tb_sobel_window_gen;

`ifdef SOBEL_WIN_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- DUT A: 3x4 ----------------
    logic       rst_a = 1'b0, pv_a = 1'b0, wr_a = 1'b1, pr_a, wv_a, wl_a;
    logic [7:0] pin_a = 8'h00;
    logic [7:0] za [1:9];

    sobel_window_gen #(.IMG_ROWS(3), .IMG_COLS(4), .PIX_W(8)) u_a (
        .clk(clk), .reset(rst_a), .pix_in(pin_a), .pix_valid(pv_a), .pix_ready(pr_a),
        .z1(za[1]), .z2(za[2]), .z3(za[3]), .z4(za[4]), .z5(za[5]),
        .z6(za[6]), .z7(za[7]), .z8(za[8]), .z9(za[9]),
        .win_valid(wv_a), .win_ready(wr_a)
`ifdef SOBEL_WIN_LAST_EN
        , .win_last(wl_a)
`endif
    );
`ifndef SOBEL_WIN_LAST_EN
    assign wl_a = 1'b0;
`endif

    // ---------------- DUT B: 5x5 ----------------
    logic       rst_b = 1'b0, pv_b = 1'b0, wr_b = 1'b1, pr_b, wv_b, wl_b;
    logic [7:0] pin_b = 8'h00;
    logic [7:0] zb [1:9];

    sobel_window_gen #(.IMG_ROWS(5), .IMG_COLS(5), .PIX_W(8)) u_b (
        .clk(clk), .reset(rst_b), .pix_in(pin_b), .pix_valid(pv_b), .pix_ready(pr_b),
        .z1(zb[1]), .z2(zb[2]), .z3(zb[3]), .z4(zb[4]), .z5(zb[5]),
        .z6(zb[6]), .z7(zb[7]), .z8(zb[8]), .z9(zb[9]),
        .win_valid(wv_b), .win_ready(wr_b)
`ifdef SOBEL_WIN_LAST_EN
        , .win_last(wl_b)
`endif
    );
`ifndef SOBEL_WIN_LAST_EN
    assign wl_b = 1'b0;
`endif

    logic [72:0] obs_a, obs_b;
    assign obs_a = {wl_a, za[1], za[2], za[3], za[4], za[5], za[6], za[7], za[8], za[9]};
    assign obs_b = {wl_b, zb[1], zb[2], zb[3], zb[4], zb[5], zb[6], zb[7], zb[8], zb[9]};

    // ---------------- reference model: frame arrays + position ----------------
    logic [7:0]  img_a [0:2][0:3];
    logic [7:0]  img_b [0:4][0:4];
    int          r_a = 0, c_a = 0, r_b = 0, c_b = 0;
    logic [72:0] q_a [$];
    logic [72:0] q_b [$];
    int          nwin_a = 0, nwin_b = 0;

    function automatic logic [72:0] win_of_a(input int r, input int c);
        logic lst;
        lst = LAST_EN && (r == 2) && (c == 3);
        return {lst, img_a[r-2][c-2], img_a[r-2][c-1], img_a[r-2][c],
                     img_a[r-1][c-2], img_a[r-1][c-1], img_a[r-1][c],
                     img_a[r][c-2],   img_a[r][c-1],   img_a[r][c]};
    endfunction

    function automatic logic [72:0] win_of_b(input int r, input int c);
        logic lst;
        lst = LAST_EN && (r == 4) && (c == 4);
        return {lst, img_b[r-2][c-2], img_b[r-2][c-1], img_b[r-2][c],
                     img_b[r-1][c-2], img_b[r-1][c-1], img_b[r-1][c],
                     img_b[r][c-2],   img_b[r][c-1],   img_b[r][c]};
    endfunction

    task automatic send_a(input logic [7:0] v);
        logic acc;
        acc  = 1'b0;
        pv_a = 1'b1;
        pin_a = v;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk); acc = pr_a;
            @(posedge clk); #1;
        end
        pv_a = 1'b0;
        check("a_accept", {79'd0, acc}, 80'd1);
        if (acc) begin
            img_a[r_a][c_a] = v;
            if (r_a >= 2 && c_a >= 2) q_a.push_back(win_of_a(r_a, c_a));
            if (c_a == 3) begin c_a = 0; r_a = (r_a == 2) ? 0 : r_a + 1; end
            else c_a++;
        end
    endtask

    task automatic send_b(input logic [7:0] v, input int idle);
        logic acc;
        acc = 1'b0;
        pv_b = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        pv_b = 1'b1;
        pin_b = v;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk); acc = pr_b;
            @(posedge clk); #1;
        end
        pv_b = 1'b0;
        check("b_accept", {79'd0, acc}, 80'd1);
        if (acc) begin
            img_b[r_b][c_b] = v;
            if (r_b >= 2 && c_b >= 2) q_b.push_back(win_of_b(r_b, c_b));
            if (c_b == 4) begin c_b = 0; r_b = (r_b == 4) ? 0 : r_b + 1; end
            else c_b++;
        end
    endtask

    task automatic frame_a(input logic [7:0] base);
        for (int i = 0; i < 12; i++) send_a(base + 8'(i));
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        q_a.delete();
        r_a = 0;
        c_a = 0;
        #1;
        check("a_reset_win_valid", {79'd0, wv_a}, 80'd0);
        check("a_reset_z", {7'd0, obs_a}, 80'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
    endtask

    // ---------------- monitors ----------------
    initial begin : mon_a
        logic        hold;
        logic [73:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_a) hold = 1'b0;
            else begin
                if (hold) check("a_hold_stable", {6'd0, wv_a, obs_a}, {6'd0, held});
                hold = 1'b0;
                if (wv_a && !wr_a) begin
                    hold = 1'b1;
                    held = {wv_a, obs_a};
                    check("a_stall_pix_ready", {79'd0, pr_a}, 80'd0);
                end else if (wv_a && wr_a) begin
                    nwin_a++;
                    if (q_a.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL a_unexpected_win: got %h expected none", obs_a);
                    end else check("a_win", {7'd0, obs_a}, {7'd0, q_a.pop_front()});
                end
            end
        end
    end

    initial begin : mon_b
        logic        hold;
        logic [73:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_b) hold = 1'b0;
            else begin
                if (hold) check("b_hold_stable", {6'd0, wv_b, obs_b}, {6'd0, held});
                hold = 1'b0;
                if (wv_b && !wr_b) begin
                    hold = 1'b1;
                    held = {wv_b, obs_b};
                    check("b_stall_pix_ready", {79'd0, pr_b}, 80'd0);
                end else if (wv_b && wr_b) begin
                    nwin_b++;
                    if (q_b.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL b_unexpected_win: got %h expected none", obs_b);
                    end else check("b_win", {7'd0, obs_b}, {7'd0, q_b.pop_front()});
                end
            end
        end
    end

    logic rnd_b = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (rnd_b) wr_b = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_state", {6'd0, wv_a, obs_a}, 80'd0);
        check("b_rst_state", {6'd0, wv_b, obs_b}, 80'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("a_pix_ready_after_reset", {79'd0, pr_a}, 80'd1);
        @(posedge clk); #1;

        // basic 3x4 frame, full throughput
        base = nwin_a;
        frame_a(8'h00);
        repeat (4) begin @(posedge clk); #1; end
        check("a_basic_count", 80'(nwin_a - base), 80'd2);

        // backpressure for 5 cycles after window 1
        base = nwin_a;
        for (int i = 0; i < 11; i++) send_a(8'(i));
        wr_a = 1'b0;
        fork
            send_a(8'h0B);
            begin repeat (5) begin @(posedge clk); #1; end wr_a = 1'b1; end
        join
        repeat (4) begin @(posedge clk); #1; end
        check("a_stall_count", 80'(nwin_a - base), 80'd2);

        // back-to-back frames
        base = nwin_a;
        frame_a(8'h00);
        frame_a(8'h10);
        repeat (4) begin @(posedge clk); #1; end
        check("a_b2b_count", 80'(nwin_a - base), 80'd4);

        // reset after 6 pixels, then a full frame
        for (int i = 0; i < 6; i++) send_a(8'h40 + 8'(i));
        reset_a();
        base = nwin_a;
        frame_a(8'h20);
        repeat (4) begin @(posedge clk); #1; end
        check("a_post_reset_count", 80'(nwin_a - base), 80'd2);

        // reset while a window is held under backpressure
        for (int i = 0; i < 11; i++) send_a(8'h50 + 8'(i));
        wr_a = 1'b0;
        reset_a();
        wr_a = 1'b1;
        base = nwin_a;
        frame_a(8'h60);
        repeat (4) begin @(posedge clk); #1; end
        check("a_held_reset_count", 80'(nwin_a - base), 80'd2);
        check("a_queue_empty", 80'(q_a.size()), 80'd0);

        // 5x5: two ramp frames then one random frame, random handshakes
        rnd_b = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    send_b(8'(r * 16 + c), int'($urandom_range(0, 2)));
        for (int i = 0; i < 25; i++) send_b(8'($urandom), int'($urandom_range(0, 2)));
        for (int i = 0; i < 3; i++) send_b(8'($urandom), 0);
        rnd_b = 1'b0;
        @(posedge clk); #1;
        wr_b = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("b_win_count", 80'(nwin_b), 80'd27);
        check("b_queue_empty", 80'(q_b.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that drives the `z1`..`z9` inputs of `sobel3x3det` from a raster-order pixel stream. It is the hardware replacement for the software window loop used in simulation. It buffers two image lines and emits one 3x3 neighbourhood per interior pixel under a valid/ready handshake, at up to one window per clock. It sits between the pixel source (frame memory or camera interface) and the Sobel datapath.

## Interface
- `IMG_ROWS`, default 436: frame height in pixels, must be ≥ 3.
- `IMG_COLS`, default 576: frame width in pixels, must be ≥ 3.
- `PIX_W`, default 8: pixel width in bits.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pix_in` in `PIX_W`: input pixel, raster order, row 0 col 0 first.
- `pix_valid` in 1: `pix_in` is valid.
- `pix_ready` out 1: the block accepts `pix_in` this cycle.
- `z1`..`z9` out `PIX_W` each: window. `z1 z2 z3` = row above, `z4 z5 z6` = centre row, `z7 z8 z9` = row below, each left to right.
- `win_valid` out 1: window on `z1`..`z9` is valid.
- `win_ready` in 1: the consumer takes the window this cycle.

## Operation
- A pixel is accepted when `pix_valid && pix_ready`.
- Counters `row` (0..`IMG_ROWS`-1) and `col` (0..`IMG_COLS`-1) track the position of the accepted pixel.
  - `col` wraps to 0 after `IMG_COLS`-1 and increments `row`.
  - `row` wraps to 0 after `IMG_ROWS`-1; the next pixel starts a new frame.
- Two line buffers, each `IMG_COLS` deep, hold rows `row`-1 and `row`-2. At each accepted pixel, for column `col`:
  - the older buffer is read;
  - the newer buffer is read and its old value moves into the older buffer;
  - `pix_in` is written into the newer buffer.
- A 3x3 shift register shifts left by one column on every accepted pixel. The new right column is {older buffer, newer buffer, `pix_in`}.
- A window is produced when the accepted pixel has `row`≥2 and `col`≥2. For source pixel s[r][c], `z1`=s[r-2][c-2] … `z9`=s[r][c], and the centre is (r-1, c-1).
- Pixels with `col`<2 or `row`<2 only update the buffers and produce no window.
- Each frame yields exactly (`IMG_ROWS`-2)*(`IMG_COLS`-2) windows, in raster order of their centres.
- Output stage:
  - `pix_ready` = !`win_valid` || `win_ready`.
  - While `win_valid && !win_ready`, `z1`..`z9` and `win_valid` hold stable and no pixel is accepted.
- Line-buffer contents are never cleared. Stale data is masked by the `row`/`col` gating.

## Timing
- Reset values: `win_valid`=0, `z1`..`z9`=0, `row`=0, `col`=0. `pix_ready`=1 once reset is deasserted.
- Latency: `win_valid` rises in the cycle after the accepting edge of the pixel that completes a window.
- Throughput: one pixel and one window per cycle while `pix_valid`=1 and `win_ready`=1.
- Simultaneous events: a window consumed and a new window produced on the same edge reloads `z*` with no bubble.
- Row boundary: after the last window of a row, `win_valid` is low for the 2 accepted pixels at `col`=0,1 of the next row.
- Frame boundary: no window is produced for the first 2 rows plus 2 pixels of the next frame.
- Reset mid-frame: counters return to 0 and `win_valid`=0 immediately. The first pixel after reset release is treated as (0,0).

## Configuration
- `SOBEL_WIN_LAST_EN` defined:
  - adds output `win_last` (1 bit);
  - `win_last` is high together with `win_valid` for the final window of a frame, centre (`IMG_ROWS`-2, `IMG_COLS`-2);
  - `win_last` holds stable under backpressure and resets to 0.
- `SOBEL_WIN_LAST_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `edge_pkg` holds:
  - `PIX_W`=8;
  - `SOBEL_OUT_W`=12, the width of `z_out`;
  - default `IMG_ROWS`/`IMG_COLS`;
  - window index constants for `z1`..`z9`.
- Sub-module `line_buffer`: one `IMG_COLS`×`PIX_W` circular RAM, read-before-write at the same address. Instantiate it twice, indexed by `col`.

## Test plan
- 3x4 frame, pixels 0x00..0x0B, `win_ready`=1:
  - window 1 is `z1`..`z9` = 00 01 02 04 05 06 08 09 0A;
  - window 2 is 01 02 03 05 06 07 09 0A 0B;
  - exactly 2 windows.
- Same frame with `win_ready`=0 for 5 cycles after window 1: `pix_ready`=0, `z*` stays equal to window 1, and window 2 appears only after `win_ready`=1.
- Two back-to-back 3x4 frames with values 0x00..0x0B then 0x10..0x1B: the second frame yields 10 11 12 14 15 16 18 19 1A and then 11 12 13 15 16 17 19 1A 1B, with no mixing of rows across frames.
- Pull `reset` low after 6 pixels of a 3x4 frame, then send a full frame: `win_valid` drops immediately and exactly 2 correct windows follow.
- 5x5 ramp (s[r][c]=r*16+c) with random `pix_valid`/`win_ready`: 9 windows, each `z5`=(r*16+c) for centres r,c∈1..3; with `SOBEL_WIN_LAST_EN`, `win_last`=1 only on the window with `z5`=0x33.
